// File: rtl/sram_like_slave_mem.sv
// rtl/sram_like_slave_mem.sv - SRAM-like req/addr_ok/data_ok responder with word memory and in-order response queue
// Optional jittered timing under macro SRAM_RANDOM_DELAY_EN.
module sram_like_slave_mem #(
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LATENCY         = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int QW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(LATENCY + 4);

  logic [31:0]           mem    [2**ADDR_WIDTH];
  logic [31:0]           q_data [MAX_OUTSTANDING];
  logic [CW-1:0]         q_cnt  [MAX_OUTSTANDING];
  logic [PW-1:0]         rel    [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] valid;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [QW-1:0]         count;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CW-1:0]         load_cnt;
  logic                  slot_free;
  logic                  accept;
  logic                  pop;
  logic                  unused_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign idx       = addr[ADDR_WIDTH+1:2];
  assign slot_free = (count < QW'(MAX_OUTSTANDING));
  assign unused_ok = ^{size, addr};

`ifdef SRAM_RANDOM_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign addr_ok  = resetn & slot_free & (lfsr[0] | lfsr[1]);
  assign load_cnt = CW'(LATENCY - 1) + CW'(lfsr[3:2]);
`else
  assign addr_ok  = resetn & slot_free;
  assign load_cnt = CW'(LATENCY - 1);
`endif

  assign accept  = req & addr_ok;
  assign pop     = (count != '0) && (q_cnt[head] == '0);
  assign data_ok = pop;
  assign rdata   = pop ? q_data[head] : 32'h0;

  // An entry is live when its distance from head (mod depth) is below count.
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      rel[i]   = PW'(i) - head;
      valid[i] = (QW'(rel[i]) < count);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        q_cnt[i]  <= '0;
        q_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (valid[i] && (q_cnt[i] != '0)) q_cnt[i] <= q_cnt[i] - 1'b1;
      end
      // Read data is captured at accept so it reflects program order.
      if (accept) begin
        q_data[tail] <= wr ? 32'h0 : mem[idx];
        q_cnt[tail]  <= load_cnt;
        tail         <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_slave_mem.sv
// tb/tb_sram_like_slave_mem.sv - self-checking bench for sram_like_slave_mem at latencies 1, 3 and 8
module tb_sram_like_slave_mem;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req1, req3, req8;
  logic        addr_ok1, addr_ok3, addr_ok8;
  logic        data_ok1, data_ok3, data_ok8;
  logic [31:0] rdata1, rdata3, rdata8;

  int edges = 0;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  sram_like_slave_mem #(.ADDR_WIDTH(12), .MAX_OUTSTANDING(4), .LATENCY(1)) u_lat1 (
    .clk(clk), .resetn(resetn), .req(req1), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1));

  sram_like_slave_mem #(.ADDR_WIDTH(12), .MAX_OUTSTANDING(4), .LATENCY(3)) u_lat3 (
    .clk(clk), .resetn(resetn), .req(req3), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3));

  sram_like_slave_mem #(.ADDR_WIDTH(12), .MAX_OUTSTANDING(4), .LATENCY(8)) u_lat8 (
    .clk(clk), .resetn(resetn), .req(req8), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok8), .data_ok(data_ok8), .rdata(rdata8));

  // Instance selector equals that instance's LATENCY.
  function automatic logic g_aok(input int sel);
    case (sel)
      1:       return addr_ok1;
      3:       return addr_ok3;
      default: return addr_ok8;
    endcase
  endfunction

  function automatic logic g_dok(input int sel);
    case (sel)
      1:       return data_ok1;
      3:       return data_ok3;
      default: return data_ok8;
    endcase
  endfunction

  function automatic logic [31:0] g_rd(input int sel);
    case (sel)
      1:       return rdata1;
      3:       return rdata3;
      default: return rdata8;
    endcase
  endfunction

  task automatic set_req(input int sel, input logic v);
    case (sel)
      1:       req1 = v;
      3:       req3 = v;
      default: req8 = v;
    endcase
  endtask

  task automatic do_op(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic ok);
    logic acc_done;
    ok = 1'b0;
    rd = 32'h0;
    acc_done = 1'b0;
    @(posedge clk); #1;
    wr = w; addr = a; wdata = d; wstrb = s;
    set_req(sel, 1'b1);
    for (int c = 0; c < 20 && !acc_done; c++) begin
      @(negedge clk);
      if (g_aok(sel)) acc_done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    set_req(sel, 1'b0);
    if (acc_done) begin
      for (int c = 0; c < 40 && !ok; c++) begin
        @(negedge clk);
        if (g_dok(sel)) begin ok = 1'b1; rd = g_rd(sel); end
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (addr_ok1 !== 1'b0) $display("FAIL reset_addr_ok1: got %b want 0", addr_ok1); else passed++;
    total++; if (data_ok1 !== 1'b0) $display("FAIL reset_data_ok1: got %b want 0", data_ok1); else passed++;
    total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata1: got %h want 0", rdata1); else passed++;
    total++; if (addr_ok8 !== 1'b0) $display("FAIL reset_addr_ok8: got %b want 0", addr_ok8); else passed++;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    total++; if (addr_ok1 !== 1'b1) $display("FAIL post_reset_addr_ok: got %b want 1", addr_ok1); else passed++;
    total++; if (data_ok1 !== 1'b0) $display("FAIL post_reset_data_ok: got %b want 0", data_ok1); else passed++;
  endtask

  task automatic test_write_read;
    @(posedge clk); #1;
    req1 = 1'b1; wr = 1'b1; addr = 32'h100; wdata = 32'h12345678; wstrb = 4'hF; size = 2'd2;
    @(negedge clk);
    total++; if (addr_ok1 !== 1'b1) $display("FAIL wr_accept: got %b want 1", addr_ok1); else passed++;
    @(posedge clk); #1;
    wr = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    @(negedge clk);
    total++; if (data_ok1 !== 1'b1) $display("FAIL wr_data_ok: got %b want 1", data_ok1); else passed++;
    total++; if (rdata1 !== 32'h0) $display("FAIL wr_rdata: got %h want 0", rdata1); else passed++;
    total++; if (addr_ok1 !== 1'b1) $display("FAIL rd_accept: got %b want 1", addr_ok1); else passed++;
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    total++; if (data_ok1 !== 1'b1) $display("FAIL rd_data_ok: got %b want 1", data_ok1); else passed++;
    total++; if (rdata1 !== 32'h12345678) $display("FAIL rd_rdata: got %h want 12345678", rdata1); else passed++;
    @(negedge clk);
    total++; if (data_ok1 !== 1'b0) $display("FAIL idle_data_ok: got %b want 0", data_ok1); else passed++;
    total++; if (rdata1 !== 32'h0) $display("FAIL idle_rdata: got %h want 0", rdata1); else passed++;
  endtask

  task automatic test_partial_write;
    logic [31:0] rd;
    logic ok;
    do_op(1, 1'b1, 32'h100, 32'h0000AB00, 4'b0010, rd, ok);
    total++; if (!ok || rd !== 32'h0) $display("FAIL partial_wr_resp: ok %b got %h want 0", ok, rd); else passed++;
    do_op(1, 1'b0, 32'h100, 32'h0, 4'h0, rd, ok);
    total++; if (!ok || rd !== 32'h1234AB78) $display("FAIL partial_rd: ok %b got %h want 1234ab78", ok, rd); else passed++;
    do_op(1, 1'b0, 32'hFFFFC103, 32'h0, 4'h0, rd, ok);
    total++; if (!ok || rd !== 32'h1234AB78) $display("FAIL alias_rd: ok %b got %h want 1234ab78", ok, rd); else passed++;
  endtask

  task automatic test_latency3;
    logic [31:0] rd;
    logic ok;
    int acc_e[$];
    int dok_e[$];
    logic [31:0] dok_d[$];
    int k;
    for (int i = 0; i < 3; i++) begin
      do_op(3, 1'b1, 32'(i * 4), 32'hA0A00000 + 32'(i), 4'hF, rd, ok);
      total++; if (!ok) $display("FAIL lat3_prewrite%0d: no response, want data_ok", i); else passed++;
    end
    k = 0;
    @(posedge clk); #1;
    req3 = 1'b1; wr = 1'b0; addr = 32'h0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (req3 && addr_ok3) begin acc_e.push_back(edges); k++; end
      if (data_ok3) begin dok_e.push_back(edges); dok_d.push_back(rdata3); end
      @(posedge clk); #1;
      if (k < 3) addr = 32'(k * 4);
      else req3 = 1'b0;
    end
    total++; if (acc_e.size() != 3) $display("FAIL lat3_accepts: got %0d want 3", acc_e.size()); else passed++;
    total++; if (dok_e.size() != 3) $display("FAIL lat3_responses: got %0d want 3", dok_e.size()); else passed++;
    if (acc_e.size() == 3 && dok_e.size() == 3) begin
      total++; if (acc_e[2] - acc_e[0] != 2) $display("FAIL lat3_b2b_accept: got span %0d want 2", acc_e[2] - acc_e[0]); else passed++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (dok_e[i] - acc_e[0] != 3 + i)
          $display("FAIL lat3_timing%0d: got offset %0d want %0d", i, dok_e[i] - acc_e[0], 3 + i);
        else passed++;
        total++;
        if (dok_d[i] !== 32'hA0A00000 + 32'(i))
          $display("FAIL lat3_data%0d: got %h want %h", i, dok_d[i], 32'hA0A00000 + 32'(i));
        else passed++;
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] rd;
    logic ok;
    logic [19:0] aok;
    int first_dok;
    int acc;
    int dcount;
    int bad;
    do_op(8, 1'b1, 32'h40, 32'h5A5A0F0F, 4'hF, rd, ok);
    total++; if (!ok) $display("FAIL sat_prewrite: no response, want data_ok"); else passed++;
    first_dok = -1; acc = 0; dcount = 0; bad = 0;
    @(posedge clk); #1;
    req8 = 1'b1; wr = 1'b0; addr = 32'h40;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      aok[i] = addr_ok8;
      if (addr_ok8) acc++;
      if (data_ok8) begin
        dcount++;
        if (first_dok < 0) first_dok = i;
        if (rdata8 !== 32'h5A5A0F0F) bad++;
      end
      @(posedge clk); #1;
    end
    req8 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (data_ok8) begin
        dcount++;
        if (rdata8 !== 32'h5A5A0F0F) bad++;
      end
    end
    total++; if (aok[3:0] !== 4'b1111) $display("FAIL sat_first4: got %b want 1111", aok[3:0]); else passed++;
    total++; if (aok[8:4] !== 5'b00000) $display("FAIL sat_full: got %b want 00000", aok[8:4]); else passed++;
    total++; if (aok[9] !== 1'b1) $display("FAIL sat_reopen: got %b want 1", aok[9]); else passed++;
    total++; if (first_dok != 8) $display("FAIL sat_first_dok: got cycle %0d want 8", first_dok); else passed++;
    total++; if (dcount != acc) $display("FAIL sat_count: got %0d responses want %0d", dcount, acc); else passed++;
    total++; if (bad != 0) $display("FAIL sat_data: got %0d bad words want 0", bad); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic ok;
    int n_acc;
    logic got;
    int stale;
    do_op(8, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, rd, ok);
    total++; if (!ok) $display("FAIL mid_prewrite: no response, want data_ok"); else passed++;
    n_acc = 0;
    @(posedge clk); #1;
    req8 = 1'b1; wr = 1'b0; addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (addr_ok8) n_acc++;
      @(posedge clk); #1;
    end
    req8 = 1'b0;
    total++; if (n_acc != 4) $display("FAIL mid_accepts: got %0d want 4", n_acc); else passed++;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (data_ok8) got = 1'b1;
    end
    total++; if (!got) $display("FAIL mid_first_dok: got none want data_ok"); else passed++;
    #1 resetn = 1'b0;
    #1;
    total++; if (addr_ok8 !== 1'b0) $display("FAIL mid_addr_ok: got %b want 0", addr_ok8); else passed++;
    total++; if (data_ok8 !== 1'b0) $display("FAIL mid_data_ok: got %b want 0", data_ok8); else passed++;
    total++; if (rdata8 !== 32'h0) $display("FAIL mid_rdata: got %h want 0", rdata8); else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (data_ok8 || data_ok1 || data_ok3) stale++;
    end
    total++; if (stale != 0) $display("FAIL mid_stale: got %0d data_ok want 0", stale); else passed++;
    do_op(1, 1'b0, 32'h100, 32'h0, 4'h0, rd, ok);
    total++; if (!ok || rd !== 32'h1234AB78) $display("FAIL mid_mem1: ok %b got %h want 1234ab78", ok, rd); else passed++;
    do_op(8, 1'b0, 32'h100, 32'h0, 4'h0, rd, ok);
    total++; if (!ok || rd !== 32'hCAFEF00D) $display("FAIL mid_mem8: ok %b got %h want cafef00d", ok, rd); else passed++;
  endtask

  // Reference: 32-word array updated in accept order, FIFO of expected responses.
  task automatic test_random(input int sel, input int n);
    logic [31:0] mm [32];
    logic [31:0] exp_d[$];
    int exp_e[$];
    logic holding;
    logic cur_w;
    logic [3:0] cur_s;
    logic [31:0] cur_a, cur_d, ed;
    int widx, acc, resp, ee;
    holding = 1'b0; acc = 0; resp = 0;
    cur_w = 1'b0; cur_s = 4'h0; cur_a = 32'h0; cur_d = 32'h0;
    for (int cyc = 0; cyc < 20000 && !(acc == n && exp_d.size() == 0); cyc++) begin
      @(posedge clk); #1;
      if (!holding) begin
        if (acc < n && ($urandom % 4) != 0) begin
          if (acc < 32) begin
            widx = acc; cur_w = 1'b1; cur_s = 4'hF;
          end else begin
            widx = int'($urandom % 32); cur_w = 1'($urandom % 2); cur_s = 4'($urandom);
          end
          cur_d = $urandom;
          cur_a = ($urandom & 32'hFFFFC000) | (32'(widx) << 2) | ($urandom & 32'h3);
          wr = cur_w; addr = cur_a; wdata = cur_d; wstrb = cur_s; size = 2'($urandom % 3);
          set_req(sel, 1'b1);
          holding = 1'b1;
        end else begin
          set_req(sel, 1'b0);
        end
      end
      @(negedge clk);
      if (holding && g_aok(sel)) begin
        widx = int'(cur_a[13:2]);
        if (cur_w) begin
          for (int b = 0; b < 4; b++) if (cur_s[b]) mm[widx][8*b +: 8] = cur_d[8*b +: 8];
          exp_d.push_back(32'h0);
        end else begin
          exp_d.push_back(mm[widx]);
        end
        exp_e.push_back(edges);
        holding = 1'b0;
        acc++;
      end
      if (g_dok(sel)) begin
        resp++;
        if (exp_d.size() == 0) begin
          total++;
          $display("FAIL rand%0d_spurious: got data_ok with %h, want no response", sel, g_rd(sel));
        end else begin
          ed = exp_d.pop_front();
          ee = exp_e.pop_front();
          total++;
          if (g_rd(sel) !== ed) $display("FAIL rand%0d_data: got %h want %h", sel, g_rd(sel), ed);
          else passed++;
          total++;
          if (edges - ee < sel) $display("FAIL rand%0d_latency: got %0d want >= %0d", sel, edges - ee, sel);
          else passed++;
        end
      end
    end
    @(posedge clk); #1;
    set_req(sel, 1'b0);
    total++; if (acc != n) $display("FAIL rand%0d_accepts: got %0d want %0d", sel, acc, n); else passed++;
    total++; if (resp != acc) $display("FAIL rand%0d_resp_count: got %0d want %0d", sel, resp, acc); else passed++;
  endtask

  initial begin
    req1 = 1'b0; req3 = 1'b0; req8 = 1'b0;
    wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    test_reset;
    test_write_read;
    test_partial_write;
    test_latency3;
    test_saturation;
    test_reset_mid;
    test_random(1, 1000);
    test_random(3, 300);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
